seg7_scan_reader: RTL and testbench
===================================

SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples (range 2..255) required before a digit is accepted.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port seg_in  input  7  segment levels ordered {a,b,c,d,e,f,g}, bit6=a.
REQ-005 SHALL have port dig_en  input  4  digit select; bit k selects digit k, where digit 0 is the least significant nibble.
REQ-006 SHALL have port value  output  16  last complete decoded frame {d3,d2,d1,d0}.
REQ-007 SHALL have port valid  output  1  one-cycle pulse when value is updated.
REQ-008 SHALL have port err  output  1  one-cycle pulse when an unrecognised pattern is accepted.
REQ-009 SHALL have port err_sticky  output  1  set by any err pulse and cleared only by rst.

Function
REQ-010 SHALL register seg_in and dig_en once (sample stage) before any other use.
REQ-011 SHALL map patterns to nibbles: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; any other pattern is invalid.
REQ-012 SHALL keep an 8-bit stability counter; a sample equal to the previous sample (pattern and dig_en) increments it, saturating at 255; any other sample reloads it to 1.
REQ-013 SHALL implement FSM states IDLE, TRACK and HOLD.
REQ-014 IDLE SHALL move to TRACK on the first sample whose dig_en is one-hot.
REQ-015 TRACK SHALL accept the digit in the cycle the counter reaches STABLE_CYCLES, then move to HOLD.
REQ-016 HOLD SHALL move to TRACK, with the counter at 1, when the sample changes.
REQ-017 A sample whose dig_en is zero or not one-hot SHALL force IDLE and SHALL NOT be accepted.
REQ-018 On acceptance of a valid pattern, the nibble SHALL be latched into the digit slot and the slot's bit set in a 4-bit capture mask.
REQ-019 On acceptance of an invalid pattern, err SHALL pulse, the slot SHALL be left unchanged and the mask bit SHALL NOT be set.
REQ-020 A repeated acceptance of an already-captured digit SHALL overwrite that slot's nibble.
REQ-021 When the mask becomes 4'b1111, the next cycle SHALL load value from the slots, pulse valid for one cycle and clear the mask.
REQ-022 Total latency SHALL be 1 (sample) + STABLE_CYCLES + 1 cycles from the last digit becoming stable at the input to valid.
REQ-023 If an acceptance coincides with the mask-clear cycle, the new digit's mask bit SHALL survive the clear.

Reset
REQ-024 rst SHALL set value=16'h0000, valid=0, err=0, err_sticky=0, mask=0, counter=0, state=IDLE and clear the sample registers.
REQ-025 rst asserted mid-frame SHALL discard all partially captured digits, with no valid pulse.

Configuration
REQ-026 With macro SEG7_ACTIVE_LOW_EN defined, seg_in and dig_en SHALL be inverted at the sample stage (active-low display), with all other behaviour unchanged.
REQ-027 Without SEG7_ACTIVE_LOW_EN, inputs SHALL be active-high as written in REQ-011.

Verification
REQ-028 Scan 1,A,3,F on digits 3..0, each held for 6 cycles, STABLE_CYCLES=4 -> exactly one valid pulse with value=16'h1A3F; err_sticky=0.
REQ-029 Hold digit0=0110000 for 3 cycles, then change it -> no acceptance and no valid pulse.
REQ-030 Present pattern 0000001 on digit2 for 5 cycles -> one err pulse, err_sticky=1, digit2 not captured.
REQ-031 dig_en=4'b0011 for 10 cycles -> state IDLE and no acceptance; the next legal scan of 8,8,8,8 -> value=16'h8888.
REQ-032 Assert rst after three digits are captured, then complete the fourth digit -> no valid pulse and value=16'h0000.
REQ-033 Build with SEG7_ACTIVE_LOW_EN and apply inverted levels for the scan 1A3F -> value=16'h1A3F.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Seven-segment scan reader: it debounces multiplexed segment/digit levels and assembles complete 4-digit hex frames.
// Optional macro SEG7_ACTIVE_LOW_EN inverts seg_in and dig_en at the sample stage for active-low displays.
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_en,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic        err_sticky
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t          state, state_nxt;
    logic [6:0]      s_seg, p_seg;
    logic [3:0]      s_dig, p_dig;
    logic [7:0]      cnt, cnt_nxt;
    logic            same, onehot, accept, full;
    logic            dec_ok;
    logic [3:0]      dec_nib;
    logic [3:0]      mask, mask_nxt;
    logic [3:0][3:0] slots;

    // s_* is the current sample; p_* is the sample from the cycle before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg <= '0;
            s_dig <= '0;
            p_seg <= '0;
            p_dig <= '0;
        end else begin
`ifdef SEG7_ACTIVE_LOW_EN
            s_seg <= ~seg_in;
            s_dig <= ~dig_en;
`else
            s_seg <= seg_in;
            s_dig <= dig_en;
`endif
            p_seg <= s_seg;
            p_dig <= s_dig;
        end
    end

    assign same    = ({s_seg, s_dig} == {p_seg, p_dig});
    assign onehot  = $onehot(s_dig);
    assign cnt_nxt = same ? ((cnt == 8'hFF) ? cnt : cnt + 8'd1) : 8'd1;
    assign full    = (mask == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_nib = 4'h0;
        case (s_seg)
            7'b1111110: dec_nib = 4'h0;
            7'b0110000: dec_nib = 4'h1;
            7'b1101101: dec_nib = 4'h2;
            7'b1111001: dec_nib = 4'h3;
            7'b0110011: dec_nib = 4'h4;
            7'b1011011: dec_nib = 4'h5;
            7'b1011111: dec_nib = 4'h6;
            7'b1110000: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1111011: dec_nib = 4'h9;
            7'b1110111: dec_nib = 4'hA;
            7'b0011111: dec_nib = 4'hB;
            7'b1001110: dec_nib = 4'hC;
            7'b0111101: dec_nib = 4'hD;
            7'b1001111: dec_nib = 4'hE;
            7'b1000111: dec_nib = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Acceptance fires on the edge where the counter reaches STABLE_CNT.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        if (!onehot) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = TRACK;
                TRACK: if (cnt_nxt == STABLE_CNT) begin
                    accept    = 1'b1;
                    state_nxt = HOLD;
                end
                HOLD:  if (!same) state_nxt = TRACK;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Clear-on-full is applied first so a coincident acceptance keeps its bit.
    always_comb begin
        mask_nxt = full ? 4'h0 : mask;
        if (accept && dec_ok) mask_nxt = mask_nxt | s_dig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask       <= '0;
            slots      <= '0;
            value      <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            mask  <= mask_nxt;
            valid <= full;
            err   <= accept && !dec_ok;
            if (full) value <= slots;
            if (accept && !dec_ok) err_sticky <= 1'b1;
            if (accept && dec_ok) begin
                for (int k = 0; k < 4; k++)
                    if (s_dig[k]) slots[k] <= dec_nib;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: a directed scenario table plus a random scan stream, both checked against a run-length reference model.
module tb_seg7_scan_reader;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_en;
    logic [15:0] value;
    logic        valid, err, err_sticky;

    seg7_scan_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en),
        .value(value), .valid(valid), .err(err), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int checks = 0;
    int errors = 0;

    // reference model: run length of identical input samples plus frame bookkeeping
    int         r;
    bit         prev_ok;
    logic [10:0] prevk;
    logic [3:0] mslots [4];
    logic [3:0] mmask;
    logic [15:0] mval;
    bit         msticky;
    bit         nx_valid, nx_err;
    int         obs_valids, obs_errs;

    typedef struct {
        logic        rst;
        logic [3:0]  dig;
        logic [6:0]  seg;
        int          hold;
        logic        chk;
        logic [15:0] e_val;
        int          e_valids;
        int          e_errs;
        logic        e_sticky;
        string       name;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (pat[i] == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        r = 0; prev_ok = 0; prevk = '0; mmask = '0; mval = '0; msticky = 0;
        for (int i = 0; i < 4; i++) mslots[i] = '0;
        nx_valid = 0; nx_err = 0;
    endtask

    task automatic model_step(input logic [6:0] s, input logic [3:0] d);
        int n, idx;
        if (prev_ok && {s, d} == prevk) r++; else r = 1;
        prevk = {s, d}; prev_ok = 1;
        nx_valid = 0; nx_err = 0;
        if (mmask == 4'hF) begin
            nx_valid = 1;
            mval = {mslots[3], mslots[2], mslots[1], mslots[0]};
            mmask = '0;
        end
        if ($countones(d) == 1 && r == STABLE) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (d[i]) idx = i;
            n = lookup(s);
            if (n < 0) begin
                nx_err = 1; msticky = 1;
            end else begin
                mslots[idx] = 4'(n);
                mmask[idx] = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic rs, input logic [6:0] s, input logic [3:0] d);
        bit ev, ee; logic [15:0] evl; bit est;
        rst = rs;
`ifdef SEG7_ACTIVE_LOW_EN
        seg_in = ~s; dig_en = ~d;
`else
        seg_in = s; dig_en = d;
`endif
        if (rs) begin
            model_reset();
            ev = 0; ee = 0; evl = '0; est = 0;
        end else begin
            ev = nx_valid; ee = nx_err; evl = mval; est = msticky;
            model_step(s, d);
        end
        @(posedge clk); #1;
        if (rs) begin
            ev = 0; ee = 0; evl = '0; est = 0;
        end
        check("valid", 32'(valid), 32'(ev));
        check("err", 32'(err), 32'(ee));
        check("value", 32'(value), 32'(evl));
        check("err_sticky", 32'(err_sticky), 32'(est));
        obs_valids += int'(valid);
        obs_errs   += int'(err);
    endtask

    task automatic add(input logic rs, input logic [3:0] d, input logic [6:0] s, input int h);
        tbl.push_back('{rs, d, s, h, 1'b0, 16'h0, 0, 0, 1'b0, ""});
    endtask

    task automatic expect_row(input string nm, input logic [15:0] v, input int nv, input int ne, input logic st);
        tbl.push_back('{1'b0, 4'h0, 7'h0, 0, 1'b1, v, nv, ne, st, nm});
    endtask

    task automatic scan4(input int a3, input int a2, input int a1, input int a0);
        add(0, 4'b1000, pat[a3], 6);
        add(0, 4'b0100, pat[a2], 6);
        add(0, 4'b0010, pat[a1], 6);
        add(0, 4'b0001, pat[a0], 6);
    endtask

    initial begin
        logic [3:0] d;
        logic [6:0] s;
        int h;
        obs_valids = 0; obs_errs = 0;
        model_reset();

        add(1, 4'h0, 7'h0, 2);
        expect_row("reset_state", 16'h0000, 0, 0, 1'b0);
        scan4(1, 10, 3, 15);
        expect_row("scan_1A3F", 16'h1A3F, 1, 0, 1'b0);
        add(1, 4'h0, 7'h0, 1);
        add(0, 4'b0001, 7'b0110000, 3);
        add(0, 4'b0001, 7'b1101101, 2);
        add(0, 4'b0010, pat[0], 6);
        add(0, 4'b0100, pat[0], 6);
        add(0, 4'b1000, pat[0], 6);
        expect_row("short_hold", 16'h0000, 0, 0, 1'b0);
        add(1, 4'h0, 7'h0, 1);
        add(0, 4'b0100, 7'b0000001, 5);
        expect_row("bad_pattern", 16'h0000, 0, 1, 1'b1);
        add(0, 4'b1000, pat[1], 6);
        add(0, 4'b0010, pat[2], 6);
        add(0, 4'b0001, pat[3], 6);
        expect_row("digit2_missing", 16'h0000, 0, 0, 1'b1);
        add(0, 4'b0100, pat[5], 6);
        expect_row("digit2_late", 16'h1523, 1, 0, 1'b1);
        add(1, 4'h0, 7'h0, 1);
        add(0, 4'b0011, pat[8], 10);
        expect_row("multi_dig_en", 16'h0000, 0, 0, 1'b0);
        scan4(8, 8, 8, 8);
        expect_row("scan_8888", 16'h8888, 1, 0, 1'b0);
        add(1, 4'h0, 7'h0, 1);
        add(0, 4'b1000, pat[1], 6);
        add(0, 4'b0100, pat[2], 6);
        add(0, 4'b0010, pat[3], 6);
        add(1, 4'h0, 7'h0, 1);
        add(0, 4'b0001, pat[4], 6);
        expect_row("rst_mid_frame", 16'h0000, 0, 0, 1'b0);
        add(1, 4'h0, 7'h0, 1);
        add(0, 4'b0001, pat[1], 6);
        add(0, 4'b0001, pat[7], 6);
        add(0, 4'b0010, pat[11], 6);
        add(0, 4'b0100, pat[12], 6);
        add(0, 4'b1000, pat[13], 6);
        expect_row("overwrite", 16'hDCB7, 1, 0, 1'b0);

        foreach (tbl[i]) begin
            if (tbl[i].chk) begin
                check({tbl[i].name, "_value"}, 32'(value), 32'(tbl[i].e_val));
                check({tbl[i].name, "_valids"}, 32'(obs_valids), 32'(tbl[i].e_valids));
                check({tbl[i].name, "_errs"}, 32'(obs_errs), 32'(tbl[i].e_errs));
                check({tbl[i].name, "_sticky"}, 32'(err_sticky), 32'(tbl[i].e_sticky));
                obs_valids = 0; obs_errs = 0;
            end else begin
                for (int c = 0; c < tbl[i].hold; c++)
                    cyc(tbl[i].rst, tbl[i].seg, tbl[i].dig);
            end
        end

        // random scan stream checked cycle by cycle against the model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                cyc(1, 7'h0, 4'h0);
            end else begin
                if ($urandom_range(0, 99) < 85) d = 4'(1 << $urandom_range(0, 3));
                else d = 4'($urandom);
                if ($urandom_range(0, 99) < 85) s = pat[$urandom_range(0, 15)];
                else s = 7'($urandom);
                h = $urandom_range(1, 8);
                for (int c = 0; c < h; c++) cyc(0, s, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
